// File: rtl/solver_result_tx.sv
// Serialises one Solver result per transaction into a framed byte stream:
// header {HDR_TAG, mode}, MSB-first zero-padded payload bytes, XOR checksum.
// Header is offered one cycle after acceptance; tx_ready stalls hold everything.
module solver_result_tx #(
  parameter logic [5:0] HDR_TAG = 6'h2A,
  parameter int         ENC_W   = 78,
  parameter int         RAW_W   = 60
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [1:0]       res_mode,
  input  logic [ENC_W-1:0] res_enc,
  input  logic [RAW_W-1:0] res_raw,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             tx_last,
  output logic [15:0]      frames_sent
);

  localparam int ENC_BYTES = (ENC_W + 7) / 8;
  localparam int RAW_BYTES = (RAW_W + 7) / 8;
  localparam int MAX_BYTES = (ENC_BYTES > RAW_BYTES) ? ENC_BYTES : RAW_BYTES;
  localparam int HOLD_W    = 8 * MAX_BYTES;
  localparam int CNT_W     = $clog2(MAX_BYTES);

  localparam logic [CNT_W-1:0] ENC_LAST = CNT_W'(ENC_BYTES - 1);
  localparam logic [CNT_W-1:0] RAW_LAST = CNT_W'(RAW_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_PAYLOAD,
    S_CHK
  } state_t;

  state_t             state_q;
  logic [1:0]         mode_q;
  logic [HOLD_W-1:0]  hold_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [7:0]         chk_q;
  logic [7:0]         tx_data_q;
  logic               tx_valid_q;
  logic               tx_last_q;
  logic               res_ready_q;
  logic [15:0]        frames_q;

  // Payload padded to whole bytes and left-aligned in the holding register,
  // so the next byte to send always sits in the top 8 bits.
  logic [HOLD_W-1:0]  enc_pad_d;
  logic [HOLD_W-1:0]  raw_pad_d;
  logic [HOLD_W-1:0]  hold_d;
  logic [CNT_W-1:0]   last_idx_d;
  logic [7:0]         next_byte_d;
  logic [HOLD_W-1:0]  hold_shift_d;

  // Select and align the incoming payload; derive byte-walk helpers.
  always_comb begin
    enc_pad_d    = HOLD_W'(res_enc) << (HOLD_W - 8 * ENC_BYTES);
    raw_pad_d    = HOLD_W'(res_raw) << (HOLD_W - 8 * RAW_BYTES);
    hold_d       = '0;
    case (res_mode)
      2'd0:    hold_d = enc_pad_d;
      2'd1,
      2'd2:    hold_d = raw_pad_d;
      default: hold_d = '0;
    endcase
    last_idx_d   = (mode_q == 2'd0) ? ENC_LAST : RAW_LAST;
    next_byte_d  = hold_q[HOLD_W-1 -: 8];
    hold_shift_d = {hold_q[HOLD_W-9:0], 8'h00};
  end

  // Frame FSM with registered handshake and byte outputs.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= S_IDLE;
      mode_q      <= 2'd0;
      hold_q      <= '0;
      cnt_q       <= '0;
      chk_q       <= 8'h00;
      tx_data_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      tx_last_q   <= 1'b0;
      res_ready_q <= 1'b1;
      frames_q    <= 16'h0000;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (res_valid && res_ready_q) begin
            mode_q      <= res_mode;
            hold_q      <= hold_d;
            tx_data_q   <= {HDR_TAG, res_mode};
            tx_valid_q  <= 1'b1;
            res_ready_q <= 1'b0;
            state_q     <= S_HDR;
          end
        end
        S_HDR: begin
          if (tx_ready) begin
            chk_q <= tx_data_q;
            cnt_q <= '0;
            if (mode_q == 2'd3) begin
              // No payload: checksum equals the header already on tx_data.
              tx_last_q <= 1'b1;
              state_q   <= S_CHK;
            end else begin
              tx_data_q <= next_byte_d;
              hold_q    <= hold_shift_d;
              state_q   <= S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (tx_ready) begin
            chk_q <= chk_q ^ tx_data_q;
            if (cnt_q == last_idx_d) begin
              tx_data_q <= chk_q ^ tx_data_q;
              tx_last_q <= 1'b1;
              state_q   <= S_CHK;
            end else begin
              cnt_q     <= cnt_q + 1'b1;
              tx_data_q <= next_byte_d;
              hold_q    <= hold_shift_d;
            end
          end
        end
        S_CHK: begin
          if (tx_ready) begin
            frames_q    <= frames_q + 16'd1;
            tx_data_q   <= 8'h00;
            tx_valid_q  <= 1'b0;
            tx_last_q   <= 1'b0;
            res_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign res_ready   = res_ready_q;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign tx_last     = tx_last_q;
  assign frames_sent = frames_q;

endmodule

// File: tb/tb_solver_result_tx.sv
// Directed + randomized frame checks for solver_result_tx against a
// byte-list reference model built from the frame format rules.
module tb_solver_result_tx;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        res_valid;
  logic        res_ready;
  logic [1:0]  res_mode;
  logic [77:0] res_enc;
  logic [59:0] res_raw;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_last;
  logic [15:0] frames_sent;

  solver_result_tx dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_mode    (res_mode),
    .res_enc     (res_enc),
    .res_raw     (res_raw),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_last     (tx_last),
    .frames_sent (frames_sent)
  );

  always #5 Clk = ~Clk;

  int          n_checks = 0;
  int          n_err    = 0;
  logic [15:0] exp_frames;
  logic [7:0]  exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference frame: header, payload bytes taken MSB-first by arithmetic, XOR sum.
  function automatic void build_frame(input logic [1:0] mode, input logic [77:0] enc,
                                      input logic [59:0] raw);
    logic [79:0] val;
    logic [79:0] sh;
    logic [7:0]  cs;
    int          nb;
    exp_q.delete();
    nb  = (mode == 2'd0) ? 10 : ((mode == 2'd3) ? 0 : 8);
    val = (mode == 2'd0) ? {2'b00, enc} : {20'h0, raw};
    cs  = {6'h2A, mode};
    exp_q.push_back(cs);
    for (int i = 0; i < nb; i++) begin
      sh = val >> (8 * (nb - 1 - i));
      exp_q.push_back(sh[7:0]);
      cs = cs ^ sh[7:0];
    end
    exp_q.push_back(cs);
  endfunction

  function automatic bit ready_pattern(input int pat, input int cyc);
    if (pat == 0) return 1'b1;
    if (pat == 1) return (cyc % 3) == 0;
    return 1'($urandom_range(0, 1));
  endfunction

  // Called at a negedge with the DUT idle. abort_idx >= 0 asserts reset while
  // that frame byte is on the bus. poke pulses res_valid mid-frame.
  task automatic run_frame(input logic [1:0] mode, input logic [77:0] enc, input logic [59:0] raw,
                           input int pat, input int abort_idx, input bit poke);
    int         guard;
    int         idx;
    int         cyc;
    bit         rdy;
    bit         stalled;
    logic [7:0] prev_data;
    guard = 0;
    while (res_ready !== 1'b1 && guard < 50) begin
      @(negedge Clk);
      guard++;
    end
    check("res_ready_idle", 32'(res_ready), 32'd1);
    build_frame(mode, enc, raw);
    res_valid = 1'b1;
    res_mode  = mode;
    res_enc   = enc;
    res_raw   = raw;
    @(negedge Clk);
    // Change inputs after acceptance: the frame must come from the latched copy.
    res_valid = 1'b0;
    res_mode  = ~mode;
    res_enc   = ~enc;
    res_raw   = ~raw;
    idx       = 0;
    cyc       = 0;
    stalled   = 1'b0;
    prev_data = 8'h00;
    while (idx < exp_q.size() && cyc < 400) begin
      check("tx_valid", 32'(tx_valid), 32'd1);
      check("tx_data", 32'(tx_data), 32'(exp_q[idx]));
      check("tx_last", 32'(tx_last), 32'(idx == exp_q.size() - 1));
      check("res_ready_busy", 32'(res_ready), 32'd0);
      if (stalled) check("stall_hold", 32'(tx_data), 32'(prev_data));
      if (idx == abort_idx) begin
        tx_ready = 1'b0;
        Rst = 1'b1;
        #1;
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_last", 32'(tx_last), 32'd0);
        check("rst_res_ready", 32'(res_ready), 32'd1);
        check("rst_frames", 32'(frames_sent), 32'd0);
        exp_frames = 16'd0;
        @(negedge Clk);
        Rst = 1'b0;
        return;
      end
      rdy       = ready_pattern(pat, cyc);
      tx_ready  = rdy;
      res_valid = poke && (cyc == 2);
      prev_data = tx_data;
      stalled   = !rdy;
      @(negedge Clk);
      if (rdy) idx++;
      cyc++;
    end
    tx_ready  = 1'b0;
    res_valid = 1'b0;
    check("frame_done", 32'(idx), 32'(exp_q.size()));
    exp_frames = exp_frames + 16'd1;
    check("frames_sent", 32'(frames_sent), 32'(exp_frames));
    check("idle_tx_valid", 32'(tx_valid), 32'd0);
    check("idle_tx_last", 32'(tx_last), 32'd0);
    check("idle_res_ready", 32'(res_ready), 32'd1);
    if (poke) begin
      @(negedge Clk);
      check("poke_ignored", 32'(tx_valid), 32'd0);
    end
  endtask

  initial begin
    logic [95:0] rnd;
    logic [1:0]  m;
    Rst        = 1'b1;
    res_valid  = 1'b0;
    res_mode   = 2'd0;
    res_enc    = '0;
    res_raw    = '0;
    tx_ready   = 1'b0;
    exp_frames = 16'd0;
    #2;
    check("reset_res_ready", 32'(res_ready), 32'd1);
    check("reset_tx_valid", 32'(tx_valid), 32'd0);
    check("reset_tx_last", 32'(tx_last), 32'd0);
    check("reset_tx_data", 32'(tx_data), 32'd0);
    check("reset_frames", 32'(frames_sent), 32'd0);
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);

    // Raw frame, no backpressure.
    run_frame(2'd1, 78'h0, 60'h123456789ABCDEF, 0, -1, 1'b0);
    // Encrypted frame, all ones.
    run_frame(2'd0, {78{1'b1}}, 60'h0, 0, -1, 1'b0);
    // Illegal mode: header + checksum only.
    run_frame(2'd3, 78'h0, 60'h0, 0, -1, 1'b0);
    // Raw frame under 1,0,0 backpressure.
    run_frame(2'd1, 78'h0, 60'h123456789ABCDEF, 1, -1, 1'b0);
    // Reset during the 4th payload byte, then a fresh mode-2 frame.
    run_frame(2'd1, 78'h0, 60'h123456789ABCDEF, 0, 4, 1'b0);
    run_frame(2'd2, 78'h0, 60'hFEDCBA987654321, 0, -1, 1'b0);

    // Randomized frames with random backpressure.
    for (int k = 0; k < 8; k++) begin
      rnd = {$urandom(), $urandom(), $urandom()};
      m   = 2'($urandom_range(0, 3));
      run_frame(m, rnd[77:0], rnd[95:36], 2, -1, 1'b0);
    end

    // Counter wrap plus an ignored mid-frame res_valid pulse.
    @(negedge Clk);
    force dut.frames_q = 16'hFFFF;
    #1;
    release dut.frames_q;
    exp_frames = 16'hFFFF;
    check("frames_preload", 32'(frames_sent), 32'hFFFF);
    run_frame(2'd2, 78'h0, 60'h0A5A5A5A5A5A5A5, 2, -1, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/solver_result_tx.md
Name: solver_result_tx

Overview:
- Output-side companion to the Solver: accepts one parallel result per transaction and transmits it as a framed byte stream with a valid/ready handshake.
- Result types: 78-bit encrypted word (work mode 0) or 60-bit raw word (work modes 1/2).
- Replaces the file-dump result path, so Solver results can leave the chip over a byte-wide link.
- Frame format: header byte, MSB-first payload bytes, XOR checksum byte.

Parameters:
- HDR_TAG, 6'h2A, upper 6 bits of every header byte.
- ENC_W, 78, encrypted payload width in bits; padded with leading zeros to a multiple of 8 (80 bits, 10 bytes).
- RAW_W, 60, raw payload width in bits; padded with leading zeros to a multiple of 8 (64 bits, 8 bytes).

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous active-high reset.
- res_valid  in  1  result presented.
- res_ready  out  1  block can accept a result.
- res_mode  in  2  work mode of the result: 0 = enc, 1 = dec, 2 = replay, 3 = illegal.
- res_enc  in  ENC_W  encrypted result, used when res_mode == 0.
- res_raw  in  RAW_W  raw result, used when res_mode == 1 or 2.
- tx_data  out  8  byte currently offered.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  sink accepts the byte.
- tx_last  out  1  current byte is the frame's checksum byte.
- frames_sent  out  16  count of completed frames; wraps from 16'hFFFF to 0.

Behaviour:
- Reset (async, immediate): state IDLE, res_ready=1, tx_valid=0, tx_last=0, tx_data=8'h00, frames_sent=0, holding register and checksum cleared.
- A reset asserted mid-frame abandons the frame. No partial frame resumes after reset.
- FSM states are IDLE, HDR, PAYLOAD and CHK.
- IDLE:
  - res_ready=1.
  - On res_valid&&res_ready at a Clk edge: latch mode and the selected payload (zero-padded, left-aligned) into the holding register, then go to HDR.
  - res_ready is a registered output: it is 0 in every state except IDLE.
- HDR:
  - tx_data = {HDR_TAG, mode}, tx_valid=1.
  - Header appears one cycle after the accepting edge.
  - On tx_ready: go to PAYLOAD, or to CHK if mode==3.
- PAYLOAD:
  - Byte counter starts at 0. tx_data = byte[counter] of the padded payload, MSB byte first.
  - Mode 0 sends 10 bytes; modes 1 and 2 send 8 bytes.
  - On tx_ready: counter increments. After the final byte is accepted, go to CHK.
- CHK:
  - tx_data = XOR of the header byte and all payload bytes sent. tx_valid=1, tx_last=1.
  - On tx_ready: frames_sent increments (wrapping), go to IDLE.
- Checksum accumulator: loaded with the header byte on header acceptance; XORed with each payload byte on acceptance.
- Backpressure: while tx_valid && !tx_ready, tx_data and tx_last are held stable and no state advances. Stall length is unbounded.
- Mode 3 frame is header + checksum only, so checksum = header byte.
- res_valid while not IDLE is ignored. The Solver holds its result until res_ready.
- Minimum frame lengths: mode 0 = 12 cycles, modes 1/2 = 10 cycles, mode 3 = 2 cycles. One extra IDLE cycle separates frames, so back-to-back throughput is 1 frame per (bytes+1) cycles.
- tx_valid never drops inside a frame except by reset.

Test Plan:
- Raw frame: mode 1, res_raw=60'h123456789ABCDEF, tx_ready=1 -> tx_data sequence A9 01 23 45 67 89 AB CD EF A9. tx_last only on the final A9. frames_sent 0->1.
- Encrypted frame: mode 0, res_enc all ones -> A8 3F FF FF FF FF FF FF FF FF FF 68 (12 bytes). Header appears exactly one cycle after acceptance.
- Illegal mode: mode 3 -> AB AB, tx_last on the second byte, no payload bytes.
- Backpressure: repeat the raw frame with tx_ready toggling 1,0,0,1,... -> identical byte sequence. tx_data stable during every stall. res_ready=0 until the cycle after the checksum is accepted.
- Reset mid-frame: assert Rst during the 4th payload byte -> tx_valid=0 and res_ready=1 immediately, frames_sent=0. A new mode-2 frame afterwards has header AA and starts at payload byte 0.
- Wrap and ignore: preload 65535 frames (or force the counter to 16'hFFFF) then send one frame -> frames_sent=0. A res_valid pulse during the frame is not accepted (no second frame appears).
